// File: rtl/edge_emitter_pkg.sv
// rtl/edge_emitter_pkg.sv - shared types and defaults for the edge emitter
// Holds the FSM state type and the default values of HOLD_CYCLES and PEND_W.
// No ports.
package edge_emitter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int HOLD_CYCLES_DEF = 4;
   localparam int PEND_W_DEF      = 3;

endpackage

// File: rtl/edge_emitter_pend.sv
// rtl/edge_emitter_pend.sv - saturating up/down counter of pending edge requests
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears count
//   inc    add one request (ignored when count is saturated)
//   dec    remove one request (an edge was emitted)
//   sat    count is at its maximum, 2^W-1
//   count  current number of pending requests
module edge_emitter_pend #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic         sat,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = 1;

   assign sat = &count;

   // inc and dec together cancel; an increment at saturation is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && !dec) begin
         if (!sat) begin
            count <= count + ONE;
         end
      end else if (dec && !inc) begin
         count <= count - ONE;
      end
   end

endmodule

// File: rtl/edge_emitter.sv
// rtl/edge_emitter.sv - turns each request pulse into one toggle of sig, spaced HOLD_CYCLES apart
// Optional feature macro: EDGE_EMITTER_OVF_EN adds the overflow output.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   req       one request per high cycle
//   sig       generated line, toggles once per accepted request
//   busy      high while holding off or requests are pending
//   pending   accepted requests not yet emitted
//   overflow  one-cycle pulse after a dropped request (EDGE_EMITTER_OVF_EN only)
module edge_emitter
   import edge_emitter_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int PEND_W      = PEND_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   output logic              sig,
   output logic              busy,
   output logic [PEND_W-1:0] pending
`ifdef EDGE_EMITTER_OVF_EN
   ,
   output logic              overflow
`endif
);

   localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hold_cnt;
   logic [7:0] hold_nxt;
   logic       emit;
   logic       demand;
   logic       sat;
   logic       drop;
   logic       inc;

   // Demand counts the request arriving this cycle, so a fresh req can be
   // emitted on the same edge even with nothing queued.
   assign demand = req | (|pending);

   // A request is lost only when the queue is full and nothing leaves it.
   assign drop = req & sat & ~emit;
   assign inc  = req & ~drop;

   edge_emitter_pend #(
      .W (PEND_W)
   ) u_pend (
      .clk   (clk),
      .reset (reset),
      .inc   (inc),
      .dec   (emit),
      .sat   (sat),
      .count (pending)
   );

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      emit      = 1'b0;
      case (state)
         IDLE: begin
            if (demand) begin
               emit      = 1'b1;
               hold_nxt  = RELOAD;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt != 8'd0) begin
               hold_nxt = hold_cnt - 8'd1;
            end else if (demand) begin
               emit     = 1'b1;
               hold_nxt = RELOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // pending can only be nonzero after a request, and any request moves the
   // FSM into HOLD, so next-state HOLD alone covers both terms of busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
         sig      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         sig      <= sig ^ emit;
         busy     <= (state_nxt == HOLD);
      end
   end

`ifdef EDGE_EMITTER_OVF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else begin
         overflow <= drop;
      end
   end
`endif

endmodule

// File: tb/tb_edge_emitter.sv
// tb/tb_edge_emitter.sv - scoreboard bench for edge_emitter (HOLD_CYCLES 4 and 1)
module tb_edge_emitter;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       req   = 1'b0;
   logic       req1  = 1'b0;
   logic       sig, busy, sig1, busy1;
   logic [2:0] pending, pending1;
`ifdef EDGE_EMITTER_OVF_EN
   logic       ovf, ovf1;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   edge_emitter #(.HOLD_CYCLES(4), .PEND_W(3)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .req      (req),
      .sig      (sig),
      .busy     (busy),
      .pending  (pending)
`ifdef EDGE_EMITTER_OVF_EN
      ,
      .overflow (ovf)
`endif
   );

   edge_emitter #(.HOLD_CYCLES(1), .PEND_W(3)) dut1 (
      .clk      (clk),
      .reset    (rst_n),
      .req      (req1),
      .sig      (sig1),
      .busy     (busy1),
      .pending  (pending1)
`ifdef EDGE_EMITTER_OVF_EN
      ,
      .overflow (ovf1)
`endif
   );

   typedef struct {
      int         cyc;
      bit         u;
      logic       s;
      logic [2:0] p;
      logic       b;
      logic       o;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int   errors = 0;
   int   checks = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, want);
      end
   endtask

   task automatic ex(int dt, bit u, logic s, int p, logic b, logic o = 1'b0);
      exp_t e;
      logic [31:0] pv;
      pv    = p;
      e.cyc = cyc + dt;
      e.u   = u;
      e.s   = s;
      e.p   = pv[2:0];
      e.b   = b;
      e.o   = o;
      sb.push_back(e);
   endtask

   // Monitor: every cycle the DUT presents its registered outputs; due entries are compared.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         me = sb.pop_front();
         if (me.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_entry: got cycle %0d expected cycle %0d", cyc, me.cyc);
         end else if (me.u) begin
            check("h1_sig", sig1, me.s);
            check("h1_pending", pending1, me.p);
            check("h1_busy", busy1, me.b);
`ifdef EDGE_EMITTER_OVF_EN
            check("h1_overflow", ovf1, me.o);
`endif
         end else begin
            check("sig", sig, me.s);
            check("pending", pending, me.p);
            check("busy", busy, me.b);
`ifdef EDGE_EMITTER_OVF_EN
            check("overflow", ovf, me.o);
`endif
         end
      end
   end

   task automatic step(logic r);
      req = r;
      @(negedge clk);
   endtask

   task automatic step1(logic r);
      req1 = r;
      @(negedge clk);
   endtask

   task automatic idle(int n);
      req  = 1'b0;
      req1 = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      req   = 1'b0;
      req1  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_sig", sig, 0);
      check("rst_pending", pending, 0);
      check("rst_busy", busy, 0);
      check("rst_h1_sig", sig1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single request: toggle next edge, busy for 4 cycles then low
      ex(1, 0, 1, 0, 1); ex(2, 0, 1, 0, 1); ex(4, 0, 1, 0, 1);
      ex(5, 0, 1, 0, 0); ex(8, 0, 1, 0, 0);
      step(1); idle(9);

      // three back-to-back requests: toggles 4 clocks apart
      do_reset();
      ex(1, 0, 1, 0, 1); ex(2, 0, 1, 1, 1); ex(3, 0, 1, 2, 1); ex(4, 0, 1, 2, 1);
      ex(5, 0, 0, 1, 1); ex(8, 0, 0, 1, 1); ex(9, 0, 1, 0, 1); ex(12, 0, 1, 0, 1);
      ex(13, 0, 1, 0, 0);
      step(1); step(1); step(1); idle(12);

      // 12 consecutive requests: pending saturates at 7, two dropped, 10 toggles
      do_reset();
      ex(1, 0, 1, 0, 1);  ex(4, 0, 1, 3, 1);  ex(9, 0, 1, 6, 1);
      ex(10, 0, 1, 7, 1); ex(11, 0, 1, 7, 1, 1); ex(12, 0, 1, 7, 1, 1);
      ex(13, 0, 0, 6, 1); ex(17, 0, 1, 5, 1); ex(37, 0, 0, 0, 1);
      ex(40, 0, 0, 0, 1); ex(41, 0, 0, 0, 0);
      repeat (12) step(1);
      idle(32);

      // reset mid-HOLD with pending=3 clears outputs without a clock edge
      do_reset();
      ex(1, 0, 1, 0, 1); ex(4, 0, 1, 3, 1);
      repeat (4) step(1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_sig", sig, 0);
      check("async_rst_pending", pending, 0);
      check("async_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      check("held_rst_pending", pending, 0);
      rst_n = 1'b1;
      req   = 1'b0;
      ex(1, 0, 0, 0, 0); ex(3, 0, 0, 0, 0); ex(6, 0, 0, 0, 0);
      idle(7);
      ex(1, 0, 1, 0, 1);
      step(1); idle(6);

      // HOLD_CYCLES=1: five requests toggle on five consecutive edges
      do_reset();
      ex(1, 1, 1, 0, 1); ex(2, 1, 0, 0, 1); ex(3, 1, 1, 0, 1);
      ex(4, 1, 0, 0, 1); ex(5, 1, 1, 0, 1); ex(6, 1, 1, 0, 0);
      repeat (5) step1(1);
      idle(4);

      // request exactly on the counter==0 cycle: toggle without an IDLE gap
      do_reset();
      ex(1, 0, 1, 0, 1); ex(4, 0, 1, 0, 1); ex(5, 0, 0, 0, 1);
      ex(8, 0, 0, 0, 1); ex(9, 0, 0, 0, 0);
      step(1); step(0); step(0); step(0); step(1);
      idle(6);

      idle(2);
      while (sb.size() > 0) begin
         me = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL unchecked_entry: got none expected check at cycle %0d", me.cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
